// File: rtl/id_operand_fetch_pkg.sv
// id_operand_fetch_pkg
//   Shared definitions for the operand-fetch stage: default widths, instruction
//   field positions and the load-use stall state encoding.
//   Build option: ID_OPERAND_FWD_EN selects the forwarding build (see top).
package id_operand_fetch_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned REG_AW_DEF = 5;

  // Low bit of each register field inside the instruction word.
  localparam int unsigned RA_LOC  = 21;
  localparam int unsigned RB_LOC  = 16;
  localparam int unsigned DST_LOC = 11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } of_state_e;

endpackage

// File: rtl/id_operand_fetch_if.sv
// id_operand_fetch_if
//   Fetch-to-decode handoff: the IF pipeline register contents plus the
//   hazard_stall back-pressure that tells IF to hold them.
//   master: IF side (drives if_*, observes hazard_stall)
//   slave : operand-fetch stage (observes if_*, drives hazard_stall)
interface id_operand_fetch_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 30
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [WORD_W-1:0] if_insn;
  logic              hazard_stall;

  modport master (
    output if_valid, if_pc, if_insn,
    input  hazard_stall
  );

  modport slave (
    input  if_valid, if_pc, if_insn,
    output hazard_stall
  );
endinterface

// File: rtl/id_operand_fetch_operand_fwd_mux.sv
// operand_fwd_mux
//   Per-source operand resolution. Purely combinational.
//   Ports:
//     src_addr_i           source register address
//     rf_data_i            register file read data for src_addr_i
//     ex_*_i / mem_*_i     in-flight writer: valid, write enable (active-low),
//                          destination, result data
//     ex_hit_o / mem_hit_o in-flight writer targets src_addr_i
//     opnd_o               resolved operand (EX wins over MEM)
//   Build option: ID_OPERAND_FWD_EN; without it the operand is always rf_data_i
//   and only the hit flags are used (for hazard detection).
module operand_fwd_mux
  import id_operand_fetch_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [WORD_W-1:0] rf_data_i,
  input  logic              ex_en_i,
  input  logic              ex_we_n_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic [WORD_W-1:0] ex_data_i,
  input  logic              mem_en_i,
  input  logic              mem_we_n_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  input  logic [WORD_W-1:0] mem_data_i,
  output logic              ex_hit_o,
  output logic              mem_hit_o,
  output logic [WORD_W-1:0] opnd_o
);

  assign ex_hit_o  = ex_en_i  & ~ex_we_n_i  & (ex_dst_i  == src_addr_i);
  assign mem_hit_o = mem_en_i & ~mem_we_n_i & (mem_dst_i == src_addr_i);

`ifdef ID_OPERAND_FWD_EN
  always_comb begin
    opnd_o = rf_data_i;
    if (ex_hit_o) begin
      opnd_o = ex_data_i;
    end else if (mem_hit_o) begin
      opnd_o = mem_data_i;
    end
  end
`else
  assign opnd_o = rf_data_i;

  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_data_i, mem_data_i};
`endif

endmodule

// File: rtl/id_operand_fetch.sv
// id_operand_fetch
//   Operand-fetch stage between the IF pipeline register and EX. Drives the two
//   register file read ports from the fetched instruction, resolves operands
//   against in-flight EX/MEM writers, detects hazards and latches the ID/EX
//   bundle with stall, flush and bubble insertion.
//   Ports:
//     clk, reset            clock; synchronous active-high reset
//     fetch (slave)         if_valid/if_pc/if_insn in, hazard_stall out
//     stall, flush          downstream hold / kill the instruction being latched
//     gpr_rd_addr_0/1       register file read addresses (ra, rb)
//     gpr_rd_data_0/1       register file read data (WB already bypassed)
//     ex_*, mem_*           in-flight writer information and results
//     id_*                  registered ID/EX bundle
//   Build option: ID_OPERAND_FWD_EN
//     defined   : EX/MEM forwarding, single bubble on load-use (RUN/BUBBLE FSM)
//     undefined : no forwarding; bubble while any EX/MEM writer matches ra/rb
module id_operand_fetch
  import id_operand_fetch_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  id_operand_fetch_if.slave fetch,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] gpr_rd_addr_0,
  output logic [REG_AW-1:0] gpr_rd_addr_1,
  input  logic [WORD_W-1:0] gpr_rd_data_0,
  input  logic [WORD_W-1:0] gpr_rd_data_1,
  input  logic              ex_en,
  input  logic              ex_gpr_we_,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [WORD_W-1:0] ex_fwd_data,
  input  logic              mem_en,
  input  logic              mem_gpr_we_,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic [WORD_W-1:0] mem_fwd_data,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_insn,
  output logic [REG_AW-1:0] id_dst_addr,
  output logic [WORD_W-1:0] id_opa,
  output logic [WORD_W-1:0] id_opb
);

  logic [REG_AW-1:0] ra, rb, dst;
  logic              ex_hit_ra, ex_hit_rb, mem_hit_ra, mem_hit_rb;
  logic [WORD_W-1:0] opa, opb;
  logic              insert_bubble;

  assign ra  = fetch.if_insn[RA_LOC  +: REG_AW];
  assign rb  = fetch.if_insn[RB_LOC  +: REG_AW];
  assign dst = fetch.if_insn[DST_LOC +: REG_AW];

  assign gpr_rd_addr_0 = ra;
  assign gpr_rd_addr_1 = rb;

  operand_fwd_mux #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_fwd_a (
    .src_addr_i (ra),
    .rf_data_i  (gpr_rd_data_0),
    .ex_en_i    (ex_en),
    .ex_we_n_i  (ex_gpr_we_),
    .ex_dst_i   (ex_dst_addr),
    .ex_data_i  (ex_fwd_data),
    .mem_en_i   (mem_en),
    .mem_we_n_i (mem_gpr_we_),
    .mem_dst_i  (mem_dst_addr),
    .mem_data_i (mem_fwd_data),
    .ex_hit_o   (ex_hit_ra),
    .mem_hit_o  (mem_hit_ra),
    .opnd_o     (opa)
  );

  operand_fwd_mux #(.WORD_W(WORD_W), .REG_AW(REG_AW)) u_fwd_b (
    .src_addr_i (rb),
    .rf_data_i  (gpr_rd_data_1),
    .ex_en_i    (ex_en),
    .ex_we_n_i  (ex_gpr_we_),
    .ex_dst_i   (ex_dst_addr),
    .ex_data_i  (ex_fwd_data),
    .mem_en_i   (mem_en),
    .mem_we_n_i (mem_gpr_we_),
    .mem_dst_i  (mem_dst_addr),
    .mem_data_i (mem_fwd_data),
    .ex_hit_o   (ex_hit_rb),
    .mem_hit_o  (mem_hit_rb),
    .opnd_o     (opb)
  );

`ifdef ID_OPERAND_FWD_EN
  // A load in EX cannot be forwarded yet; one bubble moves it to MEM where it can.
  of_state_e state_q, state_d;
  logic      load_use_raw;

  assign load_use_raw = fetch.if_valid & ex_is_load & (ex_hit_ra | ex_hit_rb);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // insert_bubble already accounts for stall/flush so the datapath only sees it
  // in cycles where the stage actually advances.
  always_comb begin
    state_d       = state_q;
    insert_bubble = 1'b0;
    if (!stall) begin
      if (flush) begin
        state_d = ST_RUN;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (load_use_raw) begin
              state_d       = ST_BUBBLE;
              insert_bubble = 1'b1;
            end
          end
          ST_BUBBLE: state_d = ST_RUN;
          default:   state_d = ST_RUN;
        endcase
      end
    end
  end

  assign fetch.hazard_stall = insert_bubble & ~reset;
`else
  // Without forwarding the instruction waits until no EX/MEM writer targets
  // either source; the writer leaves MEM within two cycles.
  logic hazard_raw;

  assign hazard_raw    = fetch.if_valid & (ex_hit_ra | ex_hit_rb | mem_hit_ra | mem_hit_rb);
  assign insert_bubble = hazard_raw & ~flush;

  assign fetch.hazard_stall = insert_bubble & ~reset;

  logic unused_load;
  assign unused_load = ex_is_load;
`endif

  logic              id_valid_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [WORD_W-1:0] id_insn_q;
  logic [REG_AW-1:0] id_dst_addr_q;
  logic [WORD_W-1:0] id_opa_q, id_opb_q;

  // Payload fields latch whenever the stage advances; only id_valid
  // distinguishes a real instruction from a flushed or bubbled slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_insn_q     <= '0;
      id_dst_addr_q <= '0;
      id_opa_q      <= '0;
      id_opb_q      <= '0;
    end else if (!stall) begin
      id_valid_q    <= fetch.if_valid & ~flush & ~insert_bubble;
      id_pc_q       <= fetch.if_pc;
      id_insn_q     <= fetch.if_insn;
      id_dst_addr_q <= dst;
      id_opa_q      <= opa;
      id_opb_q      <= opb;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_insn     = id_insn_q;
  assign id_dst_addr = id_dst_addr_q;
  assign id_opa      = id_opa_q;
  assign id_opb      = id_opb_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
module tb_id_operand_fetch;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned REG_AW = 5;
`ifdef ID_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, stall, flush;
  logic [REG_AW-1:0] gpr_rd_addr_0, gpr_rd_addr_1;
  logic [WORD_W-1:0] gpr_rd_data_0, gpr_rd_data_1;
  logic              ex_en, ex_gpr_we_, ex_is_load;
  logic [REG_AW-1:0] ex_dst_addr;
  logic [WORD_W-1:0] ex_fwd_data;
  logic              mem_en, mem_gpr_we_;
  logic [REG_AW-1:0] mem_dst_addr;
  logic [WORD_W-1:0] mem_fwd_data;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [WORD_W-1:0] id_insn;
  logic [REG_AW-1:0] id_dst_addr;
  logic [WORD_W-1:0] id_opa, id_opb;

  // Register file stand-in: contents already include same-cycle write-back.
  logic [WORD_W-1:0] rf [32];
  assign gpr_rd_data_0 = rf[gpr_rd_addr_0];
  assign gpr_rd_data_1 = rf[gpr_rd_addr_1];

  id_operand_fetch_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) fif ();

  id_operand_fetch #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch         (fif),
    .stall         (stall),
    .flush         (flush),
    .gpr_rd_addr_0 (gpr_rd_addr_0),
    .gpr_rd_addr_1 (gpr_rd_addr_1),
    .gpr_rd_data_0 (gpr_rd_data_0),
    .gpr_rd_data_1 (gpr_rd_data_1),
    .ex_en         (ex_en),
    .ex_gpr_we_    (ex_gpr_we_),
    .ex_is_load    (ex_is_load),
    .ex_dst_addr   (ex_dst_addr),
    .ex_fwd_data   (ex_fwd_data),
    .mem_en        (mem_en),
    .mem_gpr_we_   (mem_gpr_we_),
    .mem_dst_addr  (mem_dst_addr),
    .mem_fwd_data  (mem_fwd_data),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_insn       (id_insn),
    .id_dst_addr   (id_dst_addr),
    .id_opa        (id_opa),
    .id_opb        (id_opb)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              m_valid;
  logic [ADDR_W-1:0] m_pc;
  logic [WORD_W-1:0] m_insn, m_opa, m_opb;
  logic [REG_AW-1:0] m_dst;
  bit                m_paid;   // one load-use bubble already spent on this instruction
  bit                mon_en = 1'b0;

  function automatic bit writes(input logic en, input logic we_n, input logic [4:0] d, input logic [4:0] s);
    return en && !we_n && d == s;
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] s);
    if (FWD && writes(ex_en, ex_gpr_we_, ex_dst_addr, s))   return ex_fwd_data;
    if (FWD && writes(mem_en, mem_gpr_we_, mem_dst_addr, s)) return mem_fwd_data;
    return rf[s];
  endfunction

  function automatic bit m_hazard();
    logic [4:0] a, b;
    bit exw, memw;
    a    = fif.if_insn[25:21];
    b    = fif.if_insn[20:16];
    exw  = writes(ex_en, ex_gpr_we_, ex_dst_addr, a) || writes(ex_en, ex_gpr_we_, ex_dst_addr, b);
    memw = writes(mem_en, mem_gpr_we_, mem_dst_addr, a) || writes(mem_en, mem_gpr_we_, mem_dst_addr, b);
    if (FWD) return fif.if_valid && ex_is_load && exw && !m_paid;
    return fif.if_valid && (exw || memw);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_paid  <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        m_valid <= 1'b0;
        m_paid  <= 1'b0;
      end else if (m_hazard()) begin
        m_valid <= 1'b0;
        m_paid  <= 1'b1;
      end else begin
        m_valid <= fif.if_valid;
        m_pc    <= fif.if_pc;
        m_insn  <= fif.if_insn;
        m_dst   <= fif.if_insn[15:11];
        m_opa   <= m_operand(fif.if_insn[25:21]);
        m_opb   <= m_operand(fif.if_insn[20:16]);
        m_paid  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_hazard_stall", fif.hazard_stall,
          !reset && !flush && (!FWD || !stall) && m_hazard());
      chk("m_rd_addr_0", gpr_rd_addr_0, fif.if_insn[25:21]);
      chk("m_rd_addr_1", gpr_rd_addr_1, fif.if_insn[20:16]);
      chk("m_id_valid", id_valid, m_valid);
      if (m_valid) begin
        chk("m_id_pc", id_pc, m_pc);
        chk("m_id_insn", id_insn, m_insn);
        chk("m_id_dst", id_dst_addr, m_dst);
        chk("m_id_opa", id_opa, m_opa);
        chk("m_id_opb", id_opb, m_opb);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {6'h0, a, b, d, 11'h0};
  endfunction

  task automatic set_if(input logic v, input logic [ADDR_W-1:0] pc, input logic [31:0] insn);
    fif.if_valid = v;
    fif.if_pc    = pc;
    fif.if_insn  = insn;
  endtask

  task automatic set_ex(input logic en, input logic ld, input logic [4:0] d, input logic [31:0] data);
    ex_en       = en;
    ex_gpr_we_  = ~en;
    ex_is_load  = ld;
    ex_dst_addr = d;
    ex_fwd_data = data;
  endtask

  task automatic set_mem(input logic en, input logic [4:0] d, input logic [31:0] data);
    mem_en       = en;
    mem_gpr_we_  = ~en;
    mem_dst_addr = d;
    mem_fwd_data = data;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_if(1'b1, 30'h5, mk(1, 4, 9));
    set_ex(1'b1, 1'b1, 5'd1, 32'hDEAD);   // hazard present during reset must stay masked
    set_mem(1'b0, 5'd0, 32'h0);
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_insn", id_insn, 32'h0);
    chk("rst_dst", id_dst_addr, 32'h0);
    chk("rst_opa", id_opa, 32'h0);
    chk("rst_opb", id_opb, 32'h0);
    chk("rst_hazard_stall", fif.hazard_stall, 1'b0);

    // plain latch
    reset = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0, 32'h0);
    rf[1] = 32'h100; rf[4] = 32'h400;
    set_if(1'b1, 30'h10, mk(1, 4, 9));
    #1 chk("plain_hs", fif.hazard_stall, 1'b0);
    tick();
    chk("plain_valid", id_valid, 1'b1);
    chk("plain_pc", id_pc, 32'h10);
    chk("plain_insn", id_insn, 32'h0024_4800);
    chk("plain_dst", id_dst_addr, 32'd9);
    chk("plain_opa", id_opa, 32'h100);
    chk("plain_opb", id_opb, 32'h400);

    // same-cycle write-back seen through the register file
    rf[2] = 32'h55;
    set_if(1'b1, 30'h14, mk(2, 4, 9));
    tick();
    chk("wb_opa", id_opa, 32'h55);

`ifdef ID_OPERAND_FWD_EN
    rf[3] = 32'h11;
    set_ex(1'b1, 1'b0, 5'd3, 32'hAB);
    set_if(1'b1, 30'h18, mk(3, 0, 1));
    #1 chk("exfwd_hs", fif.hazard_stall, 1'b0);
    tick();
    chk("exfwd_valid", id_valid, 1'b1);
    chk("exfwd_opa", id_opa, 32'hAB);
    set_mem(1'b1, 5'd3, 32'hCD);
    tick();
    chk("exprio_opa", id_opa, 32'hAB);

    set_mem(1'b0, 5'd0, 32'h0);
    set_ex(1'b1, 1'b1, 5'd5, 32'hDEAD);
    set_if(1'b1, 30'h20, mk(0, 5, 2));
    #1 chk("lu_hs", fif.hazard_stall, 1'b1);
    tick();
    chk("lu_bubble", id_valid, 1'b0);
    set_ex(1'b0, 1'b0, 5'd0, 32'h0);
    set_mem(1'b1, 5'd5, 32'h1234);
    #1 chk("lu_hs_clear", fif.hazard_stall, 1'b0);
    tick();
    chk("lu_valid", id_valid, 1'b1);
    chk("lu_opb", id_opb, 32'h1234);
    chk("lu_pc", id_pc, 32'h20);
    set_mem(1'b0, 5'd0, 32'h0);
`else
    rf[7] = 32'h77;
    set_ex(1'b1, 1'b0, 5'd7, 32'h999);
    set_if(1'b1, 30'h30, mk(7, 0, 3));
    #1 chk("nf_hs_ex", fif.hazard_stall, 1'b1);
    tick();
    chk("nf_bubble_1", id_valid, 1'b0);
    set_ex(1'b0, 1'b0, 5'd0, 32'h0);
    set_mem(1'b1, 5'd7, 32'h999);
    #1 chk("nf_hs_mem", fif.hazard_stall, 1'b1);
    tick();
    chk("nf_bubble_2", id_valid, 1'b0);
    set_mem(1'b0, 5'd0, 32'h0);
    #1 chk("nf_hs_clear", fif.hazard_stall, 1'b0);
    tick();
    chk("nf_valid", id_valid, 1'b1);
    chk("nf_opa", id_opa, 32'h77);
    chk("nf_pc", id_pc, 32'h30);
`endif

    // stall holds the bundle
    set_if(1'b1, 30'h40, mk(1, 4, 9));
    tick();
    stall = 1'b1;
    set_if(1'b1, 30'h44, mk(2, 2, 2));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", id_valid, 1'b1);
      chk("stall_pc", id_pc, 32'h40);
      chk("stall_opa", id_opa, 32'h100);
    end
    stall = 1'b0;

    // flush during a hazard
    set_ex(1'b1, 1'b1, 5'd1, 32'hDEAD);
    set_if(1'b1, 30'h48, mk(1, 4, 9));
    flush = 1'b1;
    #1 chk("flush_hs", fif.hazard_stall, 1'b0);
    tick();
    chk("flush_valid", id_valid, 1'b0);
    flush = 1'b0;
    #1 chk("postflush_hs", fif.hazard_stall, 1'b1);
    tick();
    chk("postflush_bubble", id_valid, 1'b0);
    set_ex(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("postflush_valid", id_valid, 1'b1);
    chk("postflush_pc", id_pc, 32'h48);
    chk("postflush_opa", id_opa, 32'h100);

    set_if(1'b0, 30'h0, 32'h0);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
